// File: rtl/wavetable_reader.sv
// wavetable_reader: fetches a wavetable row (two waveform ids plus a crossfade
// factor), reads one sample from each waveform in the ROM and linearly
// crossfades them.
//
// Handshake: start is sampled only while IDLE (busy=0); any start seen while
// busy is dropped. done is a single-cycle strobe, and sample/done_voice_num
// hold their value until the next done. Memory strobes are one-cycle reads
// whose data is expected on the following cycle.
//
// Optional build macro: WTB_READER_SKIP_EQ_EN. When it is defined, a row whose
// left and right waveform ids match skips the second ROM read.
module wavetable_reader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  row,
    input  logic [7:0]  phase,
    input  logic [3:0]  voice_num,
    output logic        wtb_ram_re,
    output logic [5:0]  wtb_ram_addr_r,
    input  logic [7:0]  wtb_ram_wfm_l_r,
    input  logic [7:0]  wtb_ram_wfm_r_r,
    input  logic [7:0]  wtb_ram_factor_r,
    output logic        wfm_rom_re,
    output logic [15:0] wfm_rom_addr,
    input  logic [7:0]  wfm_rom_data,
    output logic [7:0]  sample,
    output logic [3:0]  done_voice_num,
    output logic        done,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ROW  = 3'd1,
        S_LREQ = 3'd2,
        S_RREQ = 3'd3,
        S_MIX  = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [3:0]  voice_q, voice_d;
    logic [5:0]  ram_addr_q, ram_addr_d;
    logic        ram_re_q, ram_re_d;
    logic [7:0]  factor_q, factor_d;
    logic [7:0]  sample_l_q, sample_l_d;
    logic        skip_q, skip_d;
    logic        rom_re_q, rom_re_d;
    logic [15:0] rom_addr_q, rom_addr_d;
    logic [7:0]  sample_q, sample_d;
    logic [3:0]  done_voice_q, done_voice_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    // Crossfade datapath terms
    logic [7:0]         mix_l;
    logic [7:0]         mix_r;
    logic signed [8:0]  mix_diff;
    logic signed [16:0] mix_prod;
    logic signed [16:0] mix_sum;
    logic [7:0]         mix_val;
    logic               unused_mix;

    // Crossfade: l + ((r - l) * f) >>> 8; the true result always fits 0..255,
    // so the low byte of the sum is exact.
    always_comb begin
        mix_r    = wfm_rom_data;
        mix_l    = skip_q ? wfm_rom_data : sample_l_q;
        mix_diff = $signed({1'b0, mix_r}) - $signed({1'b0, mix_l});
        mix_prod = 17'(mix_diff) * 17'($signed({1'b0, factor_q}));
        mix_sum  = $signed({9'd0, mix_l}) + (mix_prod >>> 8);
        mix_val  = mix_sum[7:0];
        unused_mix = ^mix_sum[16:8];
    end

    // Next-state and next-output computation for the request sequencer
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        voice_d      = voice_q;
        ram_addr_d   = ram_addr_q;
        ram_re_d     = 1'b0;
        factor_d     = factor_q;
        sample_l_d   = sample_l_q;
        skip_d       = skip_q;
        rom_addr_d   = rom_addr_q;
        sample_d     = sample_q;
        done_voice_d = done_voice_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    phase_d    = phase;
                    voice_d    = voice_num;
                    ram_addr_d = (row > 6'd60) ? 6'd60 : row;
                    ram_re_d   = 1'b1;
                    skip_d     = 1'b0;
                    state_d    = S_ROW;
                end
            end
            S_ROW: begin
                state_d = S_LREQ;
            end
            S_LREQ: begin
                // RAM data is live this cycle; the left ROM read is issued
                // combinationally and the address register is preloaded with
                // whatever the next (or final) ROM address should be.
                factor_d = wtb_ram_factor_r;
`ifdef WTB_READER_SKIP_EQ_EN
                if (wtb_ram_wfm_l_r == wtb_ram_wfm_r_r) begin
                    skip_d     = 1'b1;
                    rom_addr_d = {wtb_ram_wfm_l_r, phase_q};
                    state_d    = S_MIX;
                end else begin
                    rom_addr_d = {wtb_ram_wfm_r_r, phase_q};
                    state_d    = S_RREQ;
                end
`else
                rom_addr_d = {wtb_ram_wfm_r_r, phase_q};
                state_d    = S_RREQ;
`endif
            end
            S_RREQ: begin
                sample_l_d = wfm_rom_data;
                state_d    = S_MIX;
            end
            S_MIX: begin
                sample_d     = mix_val;
                done_voice_d = voice_q;
                done_d       = 1'b1;
                state_d      = S_OUT;
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rom_re_d = (state_d == S_LREQ) || (state_d == S_RREQ);
        busy_d   = (state_d != S_IDLE);
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            phase_q      <= 8'd0;
            voice_q      <= 4'd0;
            ram_addr_q   <= 6'd0;
            ram_re_q     <= 1'b0;
            factor_q     <= 8'd0;
            sample_l_q   <= 8'd0;
            skip_q       <= 1'b0;
            rom_re_q     <= 1'b0;
            rom_addr_q   <= 16'd0;
            sample_q     <= 8'd0;
            done_voice_q <= 4'd0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            voice_q      <= voice_d;
            ram_addr_q   <= ram_addr_d;
            ram_re_q     <= ram_re_d;
            factor_q     <= factor_d;
            sample_l_q   <= sample_l_d;
            skip_q       <= skip_d;
            rom_re_q     <= rom_re_d;
            rom_addr_q   <= rom_addr_d;
            sample_q     <= sample_d;
            done_voice_q <= done_voice_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign wtb_ram_re     = ram_re_q;
    assign wtb_ram_addr_r = ram_addr_q;
    assign wfm_rom_re     = rom_re_q;
    assign wfm_rom_addr   = (state_q == S_LREQ) ? {wtb_ram_wfm_l_r, phase_q} : rom_addr_q;
    assign sample         = sample_q;
    assign done_voice_num = done_voice_q;
    assign done           = done_q;
    assign busy           = busy_q;

endmodule

// File: doc/wavetable_reader.md
WAVETABLE_READER -- requirements
Module: wavetable_reader

Interface
REQ-001 SHALL provide these ports, clock and reset first: clk, in, 1, system clock; all logic on the rising edge.
REQ-002 SHALL provide rst_n, in, 1, reset; asynchronous assert, active-low.
REQ-003 SHALL provide start, in, 1, request strobe; sampled only in IDLE.
REQ-004 SHALL provide row, in, 6, wavetable RAM row index.
REQ-005 SHALL provide phase, in, 8, sample index within a waveform.
REQ-006 SHALL provide voice_num, in, 4, requesting voice tag.
REQ-007 SHALL provide wtb_ram_re, out, 1, and wtb_ram_addr_r, out, 6, the wavetable RAM read strobe and address.
REQ-008 SHALL provide wtb_ram_wfm_l_r, wtb_ram_wfm_r_r and wtb_ram_factor_r, in, 8 each, the RAM read data, valid one cycle after wtb_ram_re.
REQ-009 SHALL provide wfm_rom_re, out, 1, and wfm_rom_addr, out, 16 ({wfm_id, phase}), the waveform ROM read strobe and address.
REQ-010 SHALL provide wfm_rom_data, in, 8, unsigned ROM sample, valid one cycle after wfm_rom_re.
REQ-011 SHALL provide sample, out, 8, crossfaded result, held until the next done.
REQ-012 SHALL provide done_voice_num, out, 4, the voice tag of the last result.
REQ-013 SHALL provide done, out, 1, one-cycle result strobe.
REQ-014 SHALL provide busy, out, 1, high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ROW, LREQ, RREQ, MIX, OUT.
REQ-016 In IDLE with start=1, SHALL latch phase and voice_num, latch row clamped to 60 when greater than 60, and go to ROW; start=0 holds IDLE.
REQ-017 In ROW, SHALL drive wtb_ram_re=1 with wtb_ram_addr_r equal to the latched row.
REQ-018 In LREQ, SHALL capture wfm_l, wfm_r and factor from the RAM data, and drive wfm_rom_re=1 with wfm_rom_addr={wfm_l, phase}.
REQ-019 In RREQ, SHALL capture sample_l from wfm_rom_data, and drive wfm_rom_re=1 with wfm_rom_addr={wfm_r, phase}.
REQ-020 In MIX, SHALL capture sample_r and compute sample = sample_l + ((sample_r - sample_l) * factor) >>> 8.
REQ-021 The mix SHALL use a 9-bit signed difference, a 17-bit signed product and an arithmetic shift; the result is always in 0..255 and needs no saturation.
REQ-022 In OUT, SHALL register sample and done_voice_num, pulse done=1 for exactly one cycle, and return to IDLE.
REQ-023 Latency SHALL be fixed: with start sampled at edge k, done is high in cycle k+5 (k+4 with REQ-029 enabled and a skip taken).
REQ-024 start while busy=1 SHALL be ignored without queuing; a new request is accepted earliest in the cycle after OUT.
REQ-025 Strobes SHALL be exclusive: wtb_ram_re only in ROW; wfm_rom_re only in LREQ and RREQ; both low otherwise, with addresses held at their last value.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE and zero sample, done_voice_num, done, busy, wtb_ram_re, wtb_ram_addr_r, wfm_rom_re and wfm_rom_addr, plus all internal registers.
REQ-027 Reset mid-operation SHALL abort the request with no done pulse; after rst_n rises, the first start behaves as from power-up.

Configuration
REQ-028 Macro WTB_READER_SKIP_EQ_EN SHALL select the equal-waveform skip behaviour.
REQ-029 With WTB_READER_SKIP_EQ_EN defined, when wfm_l == wfm_r, LREQ SHALL go directly to MIX with sample_r = sample_l, so only one ROM read occurs and the latency is 4 cycles.
REQ-030 Without WTB_READER_SKIP_EQ_EN, SHALL always perform two ROM reads with the 5-cycle latency.

Verification
REQ-031 Row 3 = {l=2, r=5, f=0x80}, ROM[2,0x10]=0x40, ROM[5,0x10]=0xC0; start row=3, phase=0x10, voice=7 -> sample=0x80, done_voice_num=7, done exactly at k+5, single-cycle pulse.
REQ-032 Same row with ROM values swapped (l sample 0xC0, r sample 0x40), f=0x80 -> sample=0x80; with f=0x00 -> sample=0xC0; with f=0xFF, l=0x00, r=0xFF -> sample=0xFE.
REQ-033 start with row=63 -> wtb_ram_addr_r=60 during ROW.
REQ-034 Pulse start again at k+2 with a different voice -> ignored, exactly one done; a start at k+6 is accepted.
REQ-035 Drive rst_n low during RREQ -> all outputs 0 immediately and no done; a following request completes normally.
REQ-036 l=r=4 -> with WTB_READER_SKIP_EQ_EN, one wfm_rom_re pulse and done at k+4; without the macro, two pulses and done at k+5.
